icnd2110_output: RTL and testbench
==================================

Name: icnd2110_output

Overview:
Serial output engine for one ICND2110 LED-driver chain. It repeatedly fetches a configured block of 16-bit words from the shared frame SRAM through a request/finished handshake with the SRAM bus arbiter. Each word is shifted out MSB-first on a data/clock pin pair. A latch gap is inserted after every frame. One instance exists per output channel; the top level pulses this block's reset whenever the channel's word count or start address register is written.

Parameters:
ADDRESS_BUS_WIDTH, 16, width of start_address, word_count and read_address.
DATA_BUS_WIDTH, 16, width of read_data and of the shift register; bits shifted per word.
CLOCK_DIVIDER, 4, clk cycles per half-period of clock_out (>=1).
FRAME_GAP_CYCLES, 256, clk cycles with clock_out low between frames (latch time, >=1).

Ports:
clk  input  1  system clock (48 MHz HFOSC); the only clock.
rst  input  1  reset, synchronous, active-low.
word_count  input  ADDRESS_BUS_WIDTH  number of words per frame.
start_address  input  ADDRESS_BUS_WIDTH  SRAM word address of the first word.
read_address  output  ADDRESS_BUS_WIDTH  address of the word being requested.
read_request  output  1  high while a read is pending.
read_data  input  DATA_BUS_WIDTH  shared SRAM read data; valid only in the read_finished_strobe cycle.
read_finished_strobe  input  1  one-cycle pulse from the arbiter: read_data is valid for this channel.
data_out  output  1  serial data to the LED chain.
clock_out  output  1  serial clock to the LED chain.

Behaviour:
- Reset (rst==0 at posedge clk): state=START, word index=0, bit counter=0, phase counter=0. Outputs: read_request=0, read_address=0, data_out=0, clock_out=0. Reset overrides any transfer in progress; a pending request is dropped immediately.
- All outputs are registered. There is a single state machine: START, FETCH, SHIFT, GAP.
- START (one cycle):
  - Snapshot word_count and start_address into internal registers. Later input changes take effect only at the next START.
  - Index=0. If the snapshot count==0, go to GAP; otherwise go to FETCH.
- FETCH:
  - read_address = snapshot start + index, modulo 2^ADDRESS_BUS_WIDTH (wraps at 0xFFFF→0x0000).
  - read_request=1 from the first FETCH cycle.
  - read_request and read_address are held stable until read_finished_strobe is sampled high.
  - In the strobe cycle: capture read_data into the shift register. The next cycle shows read_request=0 and state=SHIFT.
  - clock_out stays 0 during FETCH. data_out holds its last value.
- read_finished_strobe in any state other than FETCH is ignored.
- SHIFT, per bit, starting with the MSB:
  - data_out = current MSB, and clock_out=0, for CLOCK_DIVIDER cycles.
  - Then clock_out=1 for CLOCK_DIVIDER cycles. data_out is stable across the whole bit.
  - Then shift left by one.
  - Each bit takes 2*CLOCK_DIVIDER cycles; each word is DATA_BUS_WIDTH rising edges of clock_out.
- After the last bit of a word:
  - clock_out returns to 0 and index increments.
  - If index==count, go to GAP; otherwise go to FETCH.
  - No prefetch: clock_out stays low for the whole fetch between words, so back-pressure stalls the serial clock.
- GAP:
  - clock_out=0 and data_out=0 for FRAME_GAP_CYCLES cycles, then START.
  - The frame repeats indefinitely.
- Latency: the first rising edge of clock_out occurs CLOCK_DIVIDER+1 cycles after the cycle in which the strobe is sampled.
- Index counter is ADDRESS_BUS_WIDTH bits; count=0xFFFF is legal.
- Simultaneous rst==0 and strobe: reset wins and the data is discarded.

Test Plan:
- Basic frame: start_address=0x0010, word_count=2; arbiter answers each request after 3 cycles with 0xA55A then 0x0001 -> read_address 0x0010 then 0x0011; data_out sequence 1010010101011010 then 0000000000000001, sampled on clock_out rising edges; exactly 32 rising edges; then 256 low cycles; then a request again at 0x0010.
- Timing: CLOCK_DIVIDER=4 -> clock_out high and low phases are exactly 4 cycles; data_out never changes while clock_out=1; first rise is 5 cycles after the strobe.
- Zero count: word_count=0 -> read_request never asserts; clock_out stays 0 for all time.
- Stall/hold: delay the strobe by 50 cycles -> read_request and read_address remain constant; clock_out remains 0 throughout; a strobe issued while in SHIFT or GAP is ignored and the shift register is unchanged.
- Wrap and snapshot: start_address=0xFFFF, count=2 -> addresses 0xFFFF then 0x0000; changing word_count mid-frame has no effect until the next frame.
- Reset mid-word: assert rst=0 during the 7th bit -> next cycle all outputs are 0; after release, a fresh frame starts from index 0 using the current inputs.

Source files
------------

// File: rtl/icnd2110_output.sv
// Serial output engine for one ICND2110 LED-driver chain.
// Fetches a block of words from frame SRAM and shifts them MSB-first on a data/clock pair.
module icnd2110_output #(
    parameter int unsigned ADDRESS_BUS_WIDTH = 16,
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned CLOCK_DIVIDER     = 4,
    parameter int unsigned FRAME_GAP_CYCLES  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
    input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
    output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
    output logic                         read_request,
    input  logic [DATA_BUS_WIDTH-1:0]    read_data,
    input  logic                         read_finished_strobe,
    output logic                         data_out,
    output logic                         clock_out
);

    localparam int unsigned AW      = ADDRESS_BUS_WIDTH;
    localparam int unsigned DW      = DATA_BUS_WIDTH;
    localparam int unsigned BIT_W   = (DW > 1) ? $clog2(DW) : 1;
    localparam int unsigned PHASE_W = $clog2(2 * CLOCK_DIVIDER);
    localparam int unsigned GAP_W   = (FRAME_GAP_CYCLES > 1) ? $clog2(FRAME_GAP_CYCLES) : 1;

    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(DW - 1);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(2 * CLOCK_DIVIDER - 1);
    localparam logic [PHASE_W-1:0] HIGH_PHASE = PHASE_W'(CLOCK_DIVIDER);
    localparam logic [GAP_W-1:0]   LAST_GAP   = GAP_W'(FRAME_GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_START,
        ST_FETCH,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      count_q, count_d;
    logic [AW-1:0]      start_q, start_d;
    logic [AW-1:0]      index_q, index_d;
    logic [AW-1:0]      index_inc;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] phase_inc;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [DW-1:0]      shift_q, shift_d;
    logic [AW-1:0]      read_address_d;
    logic               read_request_d;
    logic               data_out_d;
    logic               clock_out_d;

    assign index_inc = index_q + AW'(1);
    assign phase_inc = phase_q + PHASE_W'(1);

    // State and registered outputs; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_START;
            count_q      <= '0;
            start_q      <= '0;
            index_q      <= '0;
            bit_q        <= '0;
            phase_q      <= '0;
            gap_q        <= '0;
            shift_q      <= '0;
            read_address <= '0;
            read_request <= 1'b0;
            data_out     <= 1'b0;
            clock_out    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            start_q      <= start_d;
            index_q      <= index_d;
            bit_q        <= bit_d;
            phase_q      <= phase_d;
            gap_q        <= gap_d;
            shift_q      <= shift_d;
            read_address <= read_address_d;
            read_request <= read_request_d;
            data_out     <= data_out_d;
            clock_out    <= clock_out_d;
        end
    end

    // Next-state and next-output logic; clock_out defaults low outside the high half-bit.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        start_d        = start_q;
        index_d        = index_q;
        bit_d          = bit_q;
        phase_d        = phase_q;
        gap_d          = gap_q;
        shift_d        = shift_q;
        read_address_d = read_address;
        read_request_d = read_request;
        data_out_d     = data_out;
        clock_out_d    = 1'b0;

        case (state_q)
            ST_START: begin
                count_d = word_count;
                start_d = start_address;
                index_d = '0;
                gap_d   = '0;
                if (word_count == '0) begin
                    state_d        = ST_GAP;
                    read_request_d = 1'b0;
                    data_out_d     = 1'b0;
                end else begin
                    state_d        = ST_FETCH;
                    read_request_d = 1'b1;
                    read_address_d = start_address;
                end
            end

            ST_FETCH: begin
                if (read_finished_strobe) begin
                    shift_d        = read_data;
                    data_out_d     = read_data[DW-1];
                    read_request_d = 1'b0;
                    bit_d          = '0;
                    phase_d        = '0;
                    state_d        = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                phase_d     = phase_inc;
                clock_out_d = (phase_inc >= HIGH_PHASE);
                if (phase_q == LAST_PHASE) begin
                    phase_d     = '0;
                    clock_out_d = 1'b0;
                    if (bit_q == LAST_BIT) begin
                        index_d = index_inc;
                        if (index_inc == count_q) begin
                            state_d    = ST_GAP;
                            data_out_d = 1'b0;
                            gap_d      = '0;
                        end else begin
                            state_d        = ST_FETCH;
                            read_request_d = 1'b1;
                            read_address_d = start_q + index_inc;
                        end
                    end else begin
                        shift_d    = shift_q << 1;
                        data_out_d = shift_d[DW-1];
                        bit_d      = bit_q + BIT_W'(1);
                    end
                end
            end

            ST_GAP: begin
                data_out_d = 1'b0;
                if (gap_q == LAST_GAP) begin
                    state_d = ST_START;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

endmodule

// File: tb/tb_icnd2110_output.sv
// Directed bench for icnd2110_output: frame content, bit timing, stalls, wrap, snapshot and reset.
module tb_icnd2110_output;

    logic        clk;
    logic        rst;
    logic [15:0] word_count;
    logic [15:0] start_address;
    logic [15:0] read_address;
    logic        read_request;
    logic [15:0] read_data;
    logic        read_finished_strobe;
    logic        data_out;
    logic        clock_out;

    int checks = 0;
    int errors = 0;

    icnd2110_output dut (
        .clk                  (clk),
        .rst                  (rst),
        .word_count           (word_count),
        .start_address        (start_address),
        .read_address         (read_address),
        .read_request         (read_request),
        .read_data            (read_data),
        .read_finished_strobe (read_finished_strobe),
        .data_out             (data_out),
        .clock_out            (clock_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic [15:0] start, input logic [15:0] count);
        rst = 1'b0;
        start_address = start;
        word_count = count;
        read_finished_strobe = 1'b0;
        read_data = 16'h0000;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_request(output int waited);
        waited = 0;
        while (read_request !== 1'b1 && waited < 1000) begin
            tick();
            waited++;
        end
    endtask

    task automatic send_strobe(input logic [15:0] d);
        read_finished_strobe = 1'b1;
        read_data = d;
        tick();
        read_finished_strobe = 1'b0;
        read_data = 16'h0000;
    endtask

    // Collects data_out on each clock_out rising edge until 16 edges; optionally pulses a stray strobe.
    task automatic capture_word(input int inject_at, input logic [15:0] inject_data,
                                output logic [15:0] word, output int rises);
        logic prev;
        int   n;
        prev = 1'b0;
        word = 16'h0000;
        rises = 0;
        n = 0;
        while (rises < 16 && n < 400) begin
            tick();
            n++;
            read_finished_strobe = (n == inject_at);
            read_data = (n == inject_at) ? inject_data : 16'h0000;
            if (clock_out === 1'b1 && prev === 1'b0) begin
                word = {word[14:0], data_out};
                rises++;
            end
            prev = clock_out;
        end
        read_finished_strobe = 1'b0;
        read_data = 16'h0000;
    endtask

    // Counts low-clock cycles, clock rises and data highs until the next request.
    task automatic measure_gap(output int lows, output int rises, output int dhigh);
        logic prev;
        int   n;
        prev = clock_out;
        lows = 0;
        rises = 0;
        dhigh = 0;
        n = 0;
        while (n < 2000) begin
            tick();
            n++;
            if (read_request === 1'b1) break;
            if (clock_out === 1'b0) begin
                lows++;
                if (data_out !== 1'b0) dhigh++;
            end
            if (clock_out === 1'b1 && prev === 1'b0) rises++;
            prev = clock_out;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        word_count = 16'd2;
        start_address = 16'h0010;
        read_finished_strobe = 1'b0;
        read_data = 16'h0000;
        tick();
        tick();
        checks++; if (read_request !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", read_request); end
        checks++; if (read_address !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", read_address); end
        checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL reset_data got %b want 0", data_out); end
        checks++; if (clock_out !== 1'b0) begin errors++; $display("FAIL reset_clk got %b want 0", clock_out); end
    endtask

    task automatic test_basic_frame;
        int          w;
        int          r1, r2, lows, grises, dh;
        logic [15:0] word;
        apply_reset(16'h0010, 16'd2);
        wait_request(w);
        checks++; if (read_address !== 16'h0010) begin errors++; $display("FAIL basic_addr0 got %h want 0010", read_address); end
        repeat (3) tick();
        send_strobe(16'hA55A);
        capture_word(-1, 16'h0000, word, r1);
        checks++; if (word !== 16'hA55A) begin errors++; $display("FAIL basic_word0 got %h want a55a", word); end
        wait_request(w);
        checks++; if (read_address !== 16'h0011) begin errors++; $display("FAIL basic_addr1 got %h want 0011", read_address); end
        repeat (3) tick();
        send_strobe(16'h0001);
        capture_word(-1, 16'h0000, word, r2);
        checks++; if (word !== 16'h0001) begin errors++; $display("FAIL basic_word1 got %h want 0001", word); end
        measure_gap(lows, grises, dh);
        checks++; if (r1 + r2 + grises !== 32) begin errors++; $display("FAIL basic_rises got %0d want 32", r1 + r2 + grises); end
        // 256 gap cycles plus the single START cycle before the request reappears
        checks++; if (lows !== 257) begin errors++; $display("FAIL basic_gap got %0d want 257", lows); end
        checks++; if (dh !== 0) begin errors++; $display("FAIL basic_gap_data got %0d want 0", dh); end
        checks++; if (read_address !== 16'h0010 || read_request !== 1'b1) begin
            errors++; $display("FAIL basic_refetch got %h/%b want 0010/1", read_address, read_request);
        end
    endtask

    task automatic test_timing;
        int          w, k, hi, lo, bad_hi, bad_lo, unstable;
        logic        d;
        logic [15:0] word;
        apply_reset(16'h0100, 16'd1);
        wait_request(w);
        read_finished_strobe = 1'b1;
        read_data = 16'hA55A;
        tick();
        read_finished_strobe = 1'b0;
        read_data = 16'h0000;
        k = 1;
        while (clock_out !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        checks++; if (k !== 5) begin errors++; $display("FAIL timing_first_rise got %0d want 5", k); end
        bad_hi = 0; bad_lo = 0; unstable = 0; word = 16'h0000;
        for (int b = 0; b < 16; b++) begin
            hi = 0;
            d = data_out;
            word = {word[14:0], d};
            while (clock_out === 1'b1 && hi < 20) begin
                if (data_out !== d) unstable++;
                hi++;
                tick();
            end
            if (hi != 4) bad_hi++;
            if (b < 15) begin
                lo = 0;
                while (clock_out !== 1'b1 && lo < 20) begin
                    lo++;
                    tick();
                end
                if (lo != 4) bad_lo++;
            end
        end
        checks++; if (word !== 16'hA55A) begin errors++; $display("FAIL timing_word got %h want a55a", word); end
        checks++; if (bad_hi !== 0) begin errors++; $display("FAIL timing_high got %0d bad want 0", bad_hi); end
        checks++; if (bad_lo !== 0) begin errors++; $display("FAIL timing_low got %0d bad want 0", bad_lo); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL timing_stable got %0d changes want 0", unstable); end
    endtask

    task automatic test_zero_count;
        int req_seen, clk_seen;
        apply_reset(16'h0200, 16'd0);
        req_seen = 0;
        clk_seen = 0;
        repeat (600) begin
            tick();
            if (read_request !== 1'b0) req_seen++;
            if (clock_out !== 1'b0) clk_seen++;
        end
        checks++; if (req_seen !== 0) begin errors++; $display("FAIL zero_req got %0d want 0", req_seen); end
        checks++; if (clk_seen !== 0) begin errors++; $display("FAIL zero_clk got %0d want 0", clk_seen); end
    endtask

    task automatic test_stall;
        int          w, viol, r, lows, grises, dh;
        logic [15:0] a0, word;
        apply_reset(16'h1234, 16'd1);
        wait_request(w);
        a0 = read_address;
        checks++; if (a0 !== 16'h1234) begin errors++; $display("FAIL stall_addr got %h want 1234", a0); end
        viol = 0;
        repeat (50) begin
            tick();
            if (read_request !== 1'b1 || read_address !== a0 || clock_out !== 1'b0) viol++;
        end
        checks++; if (viol !== 0) begin errors++; $display("FAIL stall_hold got %0d violations want 0", viol); end
        send_strobe(16'hF00F);
        capture_word(20, 16'h0000, word, r);
        checks++; if (word !== 16'hF00F) begin errors++; $display("FAIL stall_shift_strobe got %h want f00f", word); end
        repeat (10) tick();
        send_strobe(16'hFFFF);
        measure_gap(lows, grises, dh);
        checks++; if (grises !== 0) begin errors++; $display("FAIL stall_gap_strobe got %0d rises want 0", grises); end
        checks++; if (read_address !== 16'h1234 || read_request !== 1'b1) begin
            errors++; $display("FAIL stall_refetch got %h/%b want 1234/1", read_address, read_request);
        end
    endtask

    task automatic test_wrap_snapshot;
        int          w, r, lows, grises, dh;
        logic [15:0] word;
        apply_reset(16'hFFFF, 16'd2);
        wait_request(w);
        checks++; if (read_address !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr0 got %h want ffff", read_address); end
        word_count = 16'd5;
        send_strobe(16'h1111);
        capture_word(-1, 16'h0000, word, r);
        wait_request(w);
        checks++; if (read_address !== 16'h0000) begin errors++; $display("FAIL wrap_addr1 got %h want 0000", read_address); end
        send_strobe(16'h2222);
        capture_word(-1, 16'h0000, word, r);
        checks++; if (word !== 16'h2222) begin errors++; $display("FAIL wrap_word1 got %h want 2222", word); end
        measure_gap(lows, grises, dh);
        checks++; if (lows !== 257) begin errors++; $display("FAIL snapshot_gap got %0d want 257", lows); end
        checks++; if (read_address !== 16'hFFFF) begin errors++; $display("FAIL snapshot_restart got %h want ffff", read_address); end
        send_strobe(16'h3333);
        capture_word(-1, 16'h0000, word, r);
        wait_request(w);
        send_strobe(16'h4444);
        capture_word(-1, 16'h0000, word, r);
        wait_request(w);
        checks++; if (read_address !== 16'h0001 || read_request !== 1'b1) begin
            errors++; $display("FAIL snapshot_new_count got %h/%b want 0001/1", read_address, read_request);
        end
    endtask

    task automatic test_reset_mid_word;
        int          w, n, rises, r;
        logic        prev;
        logic [15:0] word;
        apply_reset(16'h0020, 16'd3);
        wait_request(w);
        send_strobe(16'hFFFF);
        prev = 1'b0; rises = 0; n = 0;
        while (rises < 7 && n < 400) begin
            tick();
            n++;
            if (clock_out === 1'b1 && prev === 1'b0) rises++;
            prev = clock_out;
        end
        rst = 1'b0;
        start_address = 16'h0040;
        word_count = 16'd1;
        tick();
        checks++; if ({read_request, read_address, data_out, clock_out} !== 19'h0) begin
            errors++; $display("FAIL midword_reset got %b/%h/%b/%b want all 0", read_request, read_address, data_out, clock_out);
        end
        rst = 1'b1;
        wait_request(w);
        checks++; if (read_address !== 16'h0040) begin errors++; $display("FAIL midword_restart got %h want 0040", read_address); end
        rst = 1'b0;
        read_finished_strobe = 1'b1;
        read_data = 16'hFFFF;
        tick();
        rst = 1'b1;
        read_finished_strobe = 1'b0;
        read_data = 16'h0000;
        checks++; if (read_request !== 1'b0 || clock_out !== 1'b0) begin
            errors++; $display("FAIL reset_vs_strobe got %b/%b want 0/0", read_request, clock_out);
        end
        rises = 0; prev = 1'b0; n = 0;
        while (read_request !== 1'b1 && n < 100) begin
            tick();
            n++;
            if (clock_out === 1'b1 && prev === 1'b0) rises++;
            prev = clock_out;
        end
        checks++; if (rises !== 0 || read_address !== 16'h0040) begin
            errors++; $display("FAIL reset_vs_strobe_refetch got %0d rises addr %h want 0 rises addr 0040", rises, read_address);
        end
        send_strobe(16'h8001);
        capture_word(-1, 16'h0000, word, r);
        checks++; if (word !== 16'h8001) begin errors++; $display("FAIL midword_fresh_word got %h want 8001", word); end
    endtask

    initial begin
        rst = 1'b0;
        word_count = 16'd0;
        start_address = 16'h0000;
        read_data = 16'h0000;
        read_finished_strobe = 1'b0;
        test_reset();
        test_basic_frame();
        test_timing();
        test_zero_count();
        test_stall();
        test_wrap_snapshot();
        test_reset_mid_word();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
